// File: rtl/olive_multi_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and channel base-address helper
// for the olive multi-channel timer.
package olive_multi_timer_pkg;

  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] W_IRQ_PEND = 5'd0;
  localparam logic [ADDR_W-1:0] W_PRESCALE = 5'd1;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PERIOD = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int CTRL_ITO    = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_START  = 2;
  localparam int CTRL_STOP   = 3;
  localparam int CTRL_USE_PS = 4;

  localparam int STAT_TO  = 0;
  localparam int STAT_RUN = 1;

  // Channel n occupies the four words starting at 4*(n+1).
  function automatic logic [ADDR_W-1:0] ch_base(input int n);
    return ADDR_W'((n + 1) * 4);
  endfunction

endpackage

// File: rtl/olive_multi_timer_ch.sv
// One timer channel: down-counter with PERIOD reload, CTRL bits, RUN and the
// sticky timeout flag TO.
module olive_multi_timer_ch
  import olive_multi_timer_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 24999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             ctrl_wr,
  input  logic             period_wr,
  input  logic             to_clr,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] period,
  output logic             ito,
  output logic             cont,
  output logic             use_ps,
  output logic             run,
  output logic             to
);

  logic timeout;
  logic run_next;

  assign timeout = run && tick && (count == '0);

  // STOP beats START; a PERIOD write always halts the channel.
  always_comb begin
    run_next = run;
    if (timeout && !cont) run_next = 1'b0;
    if (period_wr)        run_next = 1'b0;
    if (ctrl_wr) begin
      if (wdata[CTRL_STOP])       run_next = 1'b0;
      else if (wdata[CTRL_START]) run_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= CNT_W'(DEFAULT_PERIOD);
      period <= CNT_W'(DEFAULT_PERIOD);
      ito    <= 1'b0;
      cont   <= 1'b0;
      use_ps <= 1'b0;
      run    <= 1'b0;
      to     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ito    <= wdata[CTRL_ITO];
        cont   <= wdata[CTRL_CONT];
        use_ps <= wdata[CTRL_USE_PS];
      end
      if (period_wr) begin
        period <= wdata;
        count  <= wdata;
      end else if (run && tick) begin
        count <= (count == '0) ? period : count - 1'b1;
      end
      run <= run_next;
      // A timeout in the same cycle as a clear leaves TO set.
      to  <= timeout | (to & ~to_clr);
    end
  end

endmodule

// File: rtl/olive_multi_timer.sv
// Multi-channel programmable timer: shared prescaler, register decode and
// registered read mux around NUM_CH channel instances.
module olive_multi_timer
  import olive_multi_timer_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int PRESCALE_W     = 8,
  parameter int DEFAULT_PERIOD = 24999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [4:0]        address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  logic                  wr;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] ps_cnt;
  logic                  ps_tick;
  logic [31:0]           rd_next;

  logic [NUM_CH-1:0] ito_v, cont_v, use_ps_v, run_v, to_v;
  logic [NUM_CH-1:0] tick_v, ctrl_wr_v, period_wr_v, to_clr_v;
  logic [CNT_W-1:0]  count_a  [NUM_CH];
  logic [CNT_W-1:0]  period_a [NUM_CH];

  assign wr      = chipselect && !write_n;
  assign ps_tick = (ps_cnt == prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      ps_cnt   <= '0;
    end else if (wr && address == W_PRESCALE) begin
      prescale <= writedata[PRESCALE_W-1:0];
      ps_cnt   <= '0;
    end else begin
      ps_cnt <= ps_tick ? '0 : ps_cnt + 1'b1;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic hit;
    assign hit            = ({address[4:2], 2'b00} == ch_base(n));
    assign ctrl_wr_v[n]   = wr && hit && (address[1:0] == OFF_CTRL);
    assign period_wr_v[n] = wr && hit && (address[1:0] == OFF_PERIOD);
    assign to_clr_v[n]    = wr && ((hit && address[1:0] == OFF_STATUS && writedata[STAT_TO]) ||
                                   (address == W_IRQ_PEND && writedata[n]));
    assign tick_v[n]      = use_ps_v[n] ? ps_tick : 1'b1;

    olive_multi_timer_ch #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick_v[n]),
      .ctrl_wr   (ctrl_wr_v[n]),
      .period_wr (period_wr_v[n]),
      .to_clr    (to_clr_v[n]),
      .wdata     (writedata[CNT_W-1:0]),
      .count     (count_a[n]),
      .period    (period_a[n]),
      .ito       (ito_v[n]),
      .cont      (cont_v[n]),
      .use_ps    (use_ps_v[n]),
      .run       (run_v[n]),
      .to        (to_v[n])
    );
  end

  always_comb begin
    rd_next = '0;
    if (address == W_IRQ_PEND) begin
      rd_next[NUM_CH-1:0] = to_v;
    end else if (address == W_PRESCALE) begin
      rd_next[PRESCALE_W-1:0] = prescale;
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if ({address[4:2], 2'b00} == ch_base(n)) begin
        case (address[1:0])
          OFF_CTRL:   rd_next[4:0] = {use_ps_v[n], 1'b0, run_v[n], cont_v[n], ito_v[n]};
          OFF_PERIOD: rd_next[CNT_W-1:0] = period_a[n];
          OFF_COUNT:  rd_next[CNT_W-1:0] = count_a[n];
          default:    rd_next[1:0] = {run_v[n], to_v[n]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq_vec = to_v & ito_v;
  assign irq     = |irq_vec;

endmodule

// File: tb/tb_olive_multi_timer.sv
// Directed and randomized bench for olive_multi_timer against a transaction-level
// reference model of the register map and channel timing rules.
module tb_olive_multi_timer;

  localparam int NCH  = 4;
  localparam int DEFP = 24999;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           chipselect = 1'b0;
  logic [4:0]     address = '0;
  logic           write_n = 1'b1;
  logic [31:0]    writedata = '0;
  logic [31:0]    readdata;
  logic [NCH-1:0] irq_vec;
  logic           irq;

  int tests = 0;
  int fails = 0;

  // reference model state
  int unsigned m_period [NCH];
  int unsigned m_cnt    [NCH];
  bit          m_run    [NCH];
  bit          m_to     [NCH];
  bit          m_ito    [NCH];
  bit          m_cont   [NCH];
  bit          m_ups    [NCH];
  int unsigned m_ps, m_psc;

  olive_multi_timer #(
    .NUM_CH(NCH), .CNT_W(32), .PRESCALE_W(8), .DEFAULT_PERIOD(DEFP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_vec(irq_vec), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int n = 0; n < NCH; n++) begin
      m_period[n] = DEFP; m_cnt[n] = DEFP;
      m_run[n] = 0; m_to[n] = 0; m_ito[n] = 0; m_cont[n] = 0; m_ups[n] = 0;
    end
    m_ps = 0; m_psc = 0;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    int n, off;
    if (a == 0) begin
      logic [31:0] v = '0;
      for (int k = 0; k < NCH; k++) v[k] = m_to[k];
      return v;
    end
    if (a == 1) return m_ps;
    if (a < 4 || a >= 4 * (NCH + 1)) return 0;
    n = a / 4 - 1;
    off = a % 4;
    case (off)
      0: return 32'(m_ups[n]) * 16 + 32'(m_run[n]) * 4 + 32'(m_cont[n]) * 2 + 32'(m_ito[n]);
      1: return m_period[n];
      2: return m_cnt[n];
      default: return 32'(m_run[n]) * 2 + 32'(m_to[n]);
    endcase
  endfunction

  function automatic logic [NCH-1:0] m_irq_vec();
    logic [NCH-1:0] v = '0;
    for (int n = 0; n < NCH; n++) v[n] = m_to[n] && m_ito[n];
    return v;
  endfunction

  // One bus cycle: drive, advance the model by one clock, then check outputs.
  task automatic cycle(input bit cs, input bit wn, input int a, input logic [31:0] wd);
    bit          wr = cs && !wn;
    bit          pt;
    logic [31:0] exp_rd;
    int unsigned n_cnt [NCH];
    bit          n_run [NCH];
    bit          n_to  [NCH];
    chipselect = cs; write_n = wn; address = 5'(a); writedata = wd;
    exp_rd = m_read(a);
    pt = (m_psc == m_ps);
    for (int n = 0; n < NCH; n++) begin
      int  base = 4 * (n + 1);
      bit  tk   = m_ups[n] ? pt : 1'b1;
      bit  tmo  = m_run[n] && tk && m_cnt[n] == 0;
      bit  clr  = wr && ((a == base + 3 && wd[0]) || (a == 0 && wd[n]));
      n_to[n]  = tmo || (m_to[n] && !clr);
      n_cnt[n] = m_cnt[n];
      if (m_run[n] && tk) n_cnt[n] = (m_cnt[n] == 0) ? m_period[n] : m_cnt[n] - 1;
      n_run[n] = m_run[n] && !(tmo && !m_cont[n]);
      if (wr && a == base + 1) begin
        n_cnt[n] = wd; n_run[n] = 0; m_period[n] = wd;
      end
      if (wr && a == base) begin
        if (wd[3]) n_run[n] = 0;
        else if (wd[2]) n_run[n] = 1;
        m_ito[n] = wd[0]; m_cont[n] = wd[1]; m_ups[n] = wd[4];
      end
    end
    for (int n = 0; n < NCH; n++) begin
      m_cnt[n] = n_cnt[n]; m_run[n] = n_run[n]; m_to[n] = n_to[n];
    end
    if (wr && a == 1) begin
      m_ps = wd & 32'hff; m_psc = 0;
    end else begin
      m_psc = pt ? 0 : m_psc + 1;
    end
    @(posedge clk); #1;
    chk($sformatf("readdata@%0d", a), readdata, exp_rd);
    chk("irq_vec", 32'(irq_vec), 32'(m_irq_vec()));
    chk("irq", 32'(irq), 32'(|m_irq_vec()));
  endtask

  task automatic idle(input int a);
    cycle(1'b0, 1'b1, a, 32'd0);
  endtask

  initial begin
    int k;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_readdata", readdata, 0);
    chk("reset_irq", 32'(irq), 0);
    reset_n = 1'b1;

    // default PERIOD, empty IRQ_PEND
    cycle(1, 1, 5, 0);
    chk("ch0_period_default", readdata, DEFP);
    cycle(1, 1, 0, 0);
    chk("irq_pend_reset", readdata, 0);

    // ch0 continuous, period 3
    cycle(1, 0, 5, 3);
    cycle(1, 0, 4, 32'h07);
    k = 0;
    while (irq !== 1'b1 && k < 10) begin idle(6); k++; end
    chk("ch0_irq_rises", 32'(irq), 1);
    cycle(1, 0, 0, 1);
    chk("irq_pend_clear", 32'(irq), 0);
    repeat (8) idle(6);

    // ch1 one-shot, period 2
    cycle(1, 0, 9, 2);
    cycle(1, 0, 8, 32'h05);
    repeat (4) idle(10);
    cycle(1, 1, 10, 0);
    chk("ch1_count_after", readdata, 2);
    cycle(1, 1, 11, 0);
    chk("ch1_status_oneshot", readdata, 1);

    // prescaled ch2
    cycle(1, 0, 1, 9);
    cycle(1, 0, 13, 1);
    cycle(1, 0, 12, 32'h17);
    for (int i = 0; i < 70; i++) begin
      if (i % 20 == 5) cycle(1, 0, 15, 1);
      else idle(14);
    end

    // clear colliding with a ch0 timeout
    k = 0;
    while (!(m_run[0] && m_cnt[0] == 0) && k < 20) begin idle(6); k++; end
    chk("ch0_reach_zero", 32'(k < 20), 1);
    cycle(1, 0, 7, 1);
    cycle(1, 1, 7, 0);
    chk("to_set_wins", readdata, 3);

    // PERIOD write while running
    cycle(1, 0, 5, 6);
    cycle(1, 1, 6, 0);
    chk("count_new_period", readdata, 6);
    cycle(1, 1, 7, 0);
    chk("run_cleared", 32'(readdata[1]), 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int a = $urandom_range(0, 31);
      logic [31:0] wd;
      if (a == 1) wd = $urandom_range(0, 3);
      else if (a >= 4 && a % 4 == 1) wd = $urandom_range(0, 6);
      else wd = $urandom;
      if ($urandom_range(0, 2) == 0) cycle(1, 0, a, wd);
      else cycle(1, 1, a, 0);
    end

    // reset in mid-count with a pending timeout
    cycle(1, 0, 5, 2);
    cycle(1, 0, 4, 32'h07);
    k = 0;
    while (irq_vec[0] !== 1'b1 && k < 10) begin idle(6); k++; end
    chk("pre_reset_irq", 32'(irq_vec[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_readdata", readdata, 0);
    chk("async_reset_irq", 32'(irq), 0);
    chk("async_reset_irq_vec", 32'(irq_vec), 0);
    m_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int n = 0; n < NCH; n++) begin
      cycle(1, 1, 4 * (n + 1) + 2, 0);
      chk($sformatf("ch%0d_count_reset", n), readdata, DEFP);
    end
    repeat (4) idle(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/olive_multi_timer.md
OLIVE_MULTI_TIMER -- requirements
Module: olive_multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, channel count (legal 1..7).
REQ-002 SHALL have parameter CNT_W, default 32, counter/period width (legal 16..32).
REQ-003 SHALL have parameter PRESCALE_W, default 8, prescaler divider width.
REQ-004 SHALL have parameter DEFAULT_PERIOD, default 24999, reset value of every channel's PERIOD.
REQ-005 clk  input  1  clock, all logic rising-edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 chipselect  input  1  slave select.
REQ-008 address  input  5  word address.
REQ-009 write_n  input  1  active-low write strobe; a write is chipselect && !write_n.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  read data, registered.
REQ-012 irq_vec  output  NUM_CH  per-channel interrupt, bit n = TO[n] && ITO[n].
REQ-013 irq  output  1  OR-reduction of irq_vec.

Function
REQ-014 SHALL map words as: 0 IRQ_PEND, 1 PRESCALE, 2-3 reserved; channel n at base 4*(n+1): +0 CTRL, +1 PERIOD, +2 COUNT, +3 STATUS. Unmapped words read 0 and ignore writes.
REQ-015 SHALL update readdata every cycle from the current address (1-cycle read latency); unused bits read 0.
REQ-016 IRQ_PEND: read bit n = TO[n]; writing 1 to bit n clears TO[n]; 0 bits have no effect.
REQ-017 PRESCALE: PRESCALE_W-bit register, reset 0; shared prescaler counter emits one-cycle tick every PRESCALE+1 clocks, restarting from 0 on PRESCALE write.
REQ-018 CTRL: bit0 ITO, bit1 CONT, bit4 USE_PS stored; bit2 START and bit3 STOP are write-only pulses; read returns {USE_PS,0,RUN,CONT,ITO} at bits 4..0.
REQ-019 Channel tick SHALL be every clk when USE_PS=0, else the prescaler tick.
REQ-020 While RUN=1 on a tick: counter!=0 -> decrement by 1; counter==0 -> reload PERIOD, set TO, clear RUN if CONT=0. Period P gives timeout every P+1 ticks; P=0 with CONT=1 times out every tick.
REQ-021 START sets RUN next cycle; STOP clears RUN; START and STOP in same write -> STOP wins.
REQ-022 PERIOD write SHALL store writedata[CNT_W-1:0], clear RUN, and load the counter with the new value the next cycle.
REQ-023 COUNT read SHALL return the live counter value sampled in the read cycle; COUNT writes ignored.
REQ-024 STATUS: bit0 TO (write 1 clears), bit1 RUN read-only.
REQ-025 TO set (timeout) and TO clear (STATUS or IRQ_PEND write) in the same cycle -> set wins.
REQ-026 irq/irq_vec SHALL be combinational from TO and ITO registers, no additional latency.

Reset
REQ-027 On reset_n low, asynchronously: readdata=0, PRESCALE=0, prescaler=0, all CTRL bits=0, RUN=0, TO=0, PERIOD=DEFAULT_PERIOD, counter=DEFAULT_PERIOD; hence irq=0, irq_vec=0.
REQ-028 Reset mid-count SHALL abandon the count with no timeout generated.

Structure
REQ-029 Package olive_multi_timer_pkg SHALL hold register word offsets, CTRL/STATUS bit positions and channel-base computation.
REQ-030 One sub-module olive_multi_timer_ch (counter, PERIOD, CTRL, RUN, TO) SHALL be instantiated NUM_CH times; prescaler, address decode and read mux in top.

Verification
REQ-031 Reset, read ch0 PERIOD (word 5) -> readdata=24999 one cycle later; IRQ_PEND=0; irq=0.
REQ-032 ch0 PERIOD=3, CTRL=0x07 (ITO,CONT,START) -> TO set every 4 clk; irq rises; write IRQ_PEND=1 -> irq falls next cycle.
REQ-033 ch1 PERIOD=2, CTRL=0x05 (one-shot) -> single timeout after 3 clk, RUN=0 after, COUNT reads 2.
REQ-034 PRESCALE=9, ch2 PERIOD=1, CTRL=0x17 -> timeouts every 20 clk; ch0 unaffected.
REQ-035 Write STATUS=1 in exact cycle of a ch0 timeout -> TO remains 1; write PERIOD while running -> RUN=0, COUNT equals new value.
REQ-036 Assert reset_n mid-count with TO=1 -> all outputs 0 immediately, counters=DEFAULT_PERIOD.
